// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the 32-bit MIPS datapath.
// FETCH/DECODE/EXEC/MEM/WB sequencer with a memory-ready stall and a retired-instruction counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        overflow,
  input  logic        mem_rdy,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        RegDst,
  output logic        ExtOp,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        Jump,
  output logic        MemWr,
  output logic        MemtoReg,
  output logic [2:0]  ALUctr,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  state_e      state_q, state_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  logic       is_r, is_add, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0] alu_sel;
  logic       alu_src, ext_op;

  // Instruction decode; op/func are held stable by the IR after FETCH.
  always_comb begin
    is_r    = (op == OP_RTYPE);
    is_add  = is_r && (func == FN_ADD);
    is_ori  = (op == OP_ORI);
    is_lui  = (op == OP_LUI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_j    = (op == OP_J);
    legal   = (is_r && (func == FN_ADD || func == FN_ADDU ||
                        func == FN_SUBU || func == FN_SLT)) ||
              is_ori || is_lui || is_lw || is_sw || is_beq || is_j;
    alu_sel = 3'b000;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    if (is_r) begin
      if (func == FN_SUBU)     alu_sel = 3'b001;
      else if (func == FN_SLT) alu_sel = 3'b011;
    end else if (is_ori) begin
      alu_sel = 3'b010;
      alu_src = 1'b1;
    end else if (is_lui) begin
      alu_sel = 3'b100;
      alu_src = 1'b1;
    end else if (is_lw || is_sw) begin
      alu_src = 1'b1;
      ext_op  = 1'b1;
    end else if (is_beq) begin
      alu_sel = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Handshake: in MEM the access is held (MemWr/selects stable) until mem_rdy is 1
  // at a rising edge; that edge completes it. mem_rdy is ignored outside MEM.
  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!legal) begin
          state_d = FETCH;
        end else if (is_j) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_beq) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (!mem_rdy) begin
          state_d = MEM;
        end else if (is_sw) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    instr_cnt_d = instr_cnt_q + {31'd0, retire};
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    MemWr    = 1'b0;
    MemtoReg = 1'b0;
    ALUctr   = 3'b000;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        DECODE: begin
          illegal = !legal;
          if (legal && is_j) begin
            PCWr = 1'b1;
            Jump = 1'b1;
          end
        end
        EXEC: begin
          ALUctr = alu_sel;
          ALUSrc = alu_src;
          ExtOp  = ext_op;
          if (is_beq) begin
            Branch = 1'b1;
            PCWr   = zero;
          end
        end
        MEM: begin
          ALUctr = alu_sel;
          ALUSrc = alu_src;
          ExtOp  = ext_op;
          MemWr  = is_sw;
        end
        WB: begin
          ALUctr   = alu_sel;
          ALUSrc   = alu_src;
          ExtOp    = ext_op;
          // A signed-overflowing add suppresses its write but still retires.
          RegWr    = !(is_add && overflow);
          RegDst   = is_r;
          MemtoReg = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state and control-vector checks
// across every supported opcode, reset mid-MEM, stalls and counter wrap.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, func;
  logic        zero, overflow, mem_rdy;
  logic        PCWr, IRWr, RegWr, RegDst, ExtOp, ALUSrc, Branch, Jump, MemWr, MemtoReg;
  logic [2:0]  ALUctr, state;
  logic        illegal;
  logic [31:0] instr_cnt;

  int total = 0;
  int bad   = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .overflow(overflow), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp),
    .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump), .MemWr(MemWr),
    .MemtoReg(MemtoReg), .ALUctr(ALUctr), .state(state), .illegal(illegal),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {PCWr, IRWr, RegWr, RegDst, ExtOp, ALUSrc, Branch, Jump,
                MemWr, MemtoReg, ALUctr, illegal};

  function automatic logic [13:0] ctl(input logic pc, ir, rw, rd, ext, src,
                                      br, jp, mw, m2r, input logic [2:0] alu,
                                      input logic ill);
    return {pc, ir, rw, rd, ext, src, br, jp, mw, m2r, alu, ill};
  endfunction

  logic [13:0] c_zero, c_fetch, c_ldst;

  // Check state and controls for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [13:0] ec);
    #1;
    total++;
    assert (state === es) else begin
      bad++;
      $error("FAIL %s state got=%0d exp=%0d", tag, state, es);
    end
    total++;
    assert (obs === ec) else begin
      bad++;
      $error("FAIL %s ctl got=%b exp=%b", tag, obs, ec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] e);
    total++;
    assert (instr_cnt === e) else begin
      bad++;
      $error("FAIL %s instr_cnt got=%h exp=%h", tag, instr_cnt, e);
    end
  endtask

  initial begin
    c_zero  = ctl(0,0,0,0,0,0,0,0,0,0,3'b000,0);
    c_fetch = ctl(1,1,0,0,0,0,0,0,0,0,3'b000,0);
    c_ldst  = ctl(0,0,0,0,1,1,0,0,0,0,3'b000,0);
    rst = 1'b1; op = 6'b0; func = 6'b0; zero = 1'b0; overflow = 1'b0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;

    // Power-up reset
    chk_cnt("rst_cnt0", 32'd0);
    cyc("rst_a", 3'd0, c_zero);
    rst = 1'b0;

    // Start an lw, reset it while stalled in MEM
    op = 6'b100011;
    cyc("lw0_fetch", 3'd0, c_fetch);
    cyc("lw0_dec", 3'd1, c_zero);
    cyc("lw0_ex", 3'd2, c_ldst);
    cyc("lw0_mem", 3'd3, c_ldst);
    rst = 1'b1;
    cyc("rst_mem", 3'd3, c_zero);
    chk_cnt("rst_mem_cnt", 32'd0);
    cyc("rst_hold", 3'd0, c_zero);
    rst = 1'b0;

    // addu
    op = 6'b000000; func = 6'b100001;
    cyc("addu_fetch", 3'd0, c_fetch);
    cyc("addu_dec", 3'd1, c_zero);
    cyc("addu_ex", 3'd2, c_zero);
    cyc("addu_wb", 3'd4, ctl(0,0,1,1,0,0,0,0,0,0,3'b000,0));
    chk_cnt("addu_cnt", 32'd1);

    // lw with three wait cycles
    op = 6'b100011;
    cyc("lw_fetch", 3'd0, c_fetch);
    cyc("lw_dec", 3'd1, c_zero);
    cyc("lw_ex", 3'd2, c_ldst);
    cyc("lw_mem1", 3'd3, c_ldst);
    cyc("lw_mem2", 3'd3, c_ldst);
    cyc("lw_mem3", 3'd3, c_ldst);
    mem_rdy = 1'b1;
    cyc("lw_mem4", 3'd3, c_ldst);
    mem_rdy = 1'b0;
    cyc("lw_wb", 3'd4, ctl(0,0,1,0,1,1,0,0,0,1,3'b000,0));
    chk_cnt("lw_cnt", 32'd2);

    // sw with one wait cycle
    op = 6'b101011;
    cyc("sw_fetch", 3'd0, c_fetch);
    cyc("sw_dec", 3'd1, c_zero);
    cyc("sw_ex", 3'd2, c_ldst);
    cyc("sw_mem1", 3'd3, ctl(0,0,0,0,1,1,0,0,1,0,3'b000,0));
    mem_rdy = 1'b1;
    cyc("sw_mem2", 3'd3, ctl(0,0,0,0,1,1,0,0,1,0,3'b000,0));
    mem_rdy = 1'b0;
    chk_cnt("sw_cnt", 32'd3);

    // beq taken, then not taken
    op = 6'b000100; zero = 1'b1;
    cyc("beq1_fetch", 3'd0, c_fetch);
    cyc("beq1_dec", 3'd1, c_zero);
    cyc("beq1_ex", 3'd2, ctl(1,0,0,0,0,0,1,0,0,0,3'b001,0));
    chk_cnt("beq1_cnt", 32'd4);
    zero = 1'b0;
    cyc("beq0_fetch", 3'd0, c_fetch);
    cyc("beq0_dec", 3'd1, c_zero);
    cyc("beq0_ex", 3'd2, ctl(0,0,0,0,0,0,1,0,0,0,3'b001,0));
    chk_cnt("beq0_cnt", 32'd5);

    // add with overflow: no write, still retires
    op = 6'b000000; func = 6'b100000; overflow = 1'b1;
    cyc("addov_fetch", 3'd0, c_fetch);
    cyc("addov_dec", 3'd1, c_zero);
    cyc("addov_ex", 3'd2, c_zero);
    cyc("addov_wb", 3'd4, ctl(0,0,0,1,0,0,0,0,0,0,3'b000,0));
    overflow = 1'b0;
    chk_cnt("addov_cnt", 32'd6);

    // ori
    op = 6'b001101;
    cyc("ori_fetch", 3'd0, c_fetch);
    cyc("ori_dec", 3'd1, c_zero);
    cyc("ori_ex", 3'd2, ctl(0,0,0,0,0,1,0,0,0,0,3'b010,0));
    cyc("ori_wb", 3'd4, ctl(0,0,1,0,0,1,0,0,0,0,3'b010,0));
    chk_cnt("ori_cnt", 32'd7);

    // lui
    op = 6'b001111;
    cyc("lui_fetch", 3'd0, c_fetch);
    cyc("lui_dec", 3'd1, c_zero);
    cyc("lui_ex", 3'd2, ctl(0,0,0,0,0,1,0,0,0,0,3'b100,0));
    cyc("lui_wb", 3'd4, ctl(0,0,1,0,0,1,0,0,0,0,3'b100,0));
    chk_cnt("lui_cnt", 32'd8);

    // slt, with overflow high to show it only masks add
    op = 6'b000000; func = 6'b101010; overflow = 1'b1;
    cyc("slt_fetch", 3'd0, c_fetch);
    cyc("slt_dec", 3'd1, c_zero);
    cyc("slt_ex", 3'd2, ctl(0,0,0,0,0,0,0,0,0,0,3'b011,0));
    cyc("slt_wb", 3'd4, ctl(0,0,1,1,0,0,0,0,0,0,3'b011,0));
    overflow = 1'b0;
    chk_cnt("slt_cnt", 32'd9);

    // subu
    func = 6'b100011;
    cyc("subu_fetch", 3'd0, c_fetch);
    cyc("subu_dec", 3'd1, c_zero);
    cyc("subu_ex", 3'd2, ctl(0,0,0,0,0,0,0,0,0,0,3'b001,0));
    cyc("subu_wb", 3'd4, ctl(0,0,1,1,0,0,0,0,0,0,3'b001,0));
    chk_cnt("subu_cnt", 32'd10);

    // Illegal opcode and illegal R-type func
    op = 6'b111111;
    cyc("ill_op_fetch", 3'd0, c_fetch);
    cyc("ill_op_dec", 3'd1, ctl(0,0,0,0,0,0,0,0,0,0,3'b000,1));
    chk_cnt("ill_op_cnt", 32'd10);
    op = 6'b000000; func = 6'b000000;
    cyc("ill_fn_fetch", 3'd0, c_fetch);
    cyc("ill_fn_dec", 3'd1, ctl(0,0,0,0,0,0,0,0,0,0,3'b000,1));
    chk_cnt("ill_fn_cnt", 32'd10);

    // j with counter preloaded to all-ones: wraps to zero
    op = 6'b000010;
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    cyc("j_fetch", 3'd0, c_fetch);
    chk_cnt("j_pre_cnt", 32'hFFFF_FFFF);
    cyc("j_dec", 3'd1, ctl(1,0,0,0,0,0,0,1,0,0,3'b000,0));
    chk_cnt("j_wrap_cnt", 32'd0);
    cyc("j_next_fetch", 3'd0, c_fetch);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout state=%0d", state);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the 32-bit MIPS datapath. It replaces the single-cycle `ctrl`/`ALUctrl` pair: a 5-state FSM issues per-cycle write strobes and mux selects to the PC, instruction register, register file, ALU and data memory. It stretches the memory phase on a data-memory ready handshake and counts retired instructions. It sits between the instruction register (`op`/`func`) and the datapath enables.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: `IR[31:26]`, stable from the cycle after FETCH.
- `func` in 6: `IR[5:0]`.
- `zero` in 1: ALU zero flag.
- `overflow` in 1: ALU signed-overflow flag.
- `mem_rdy` in 1: data memory ready for the current access.
- `PCWr` out 1: PC load strobe.
- `IRWr` out 1: instruction register load.
- `RegWr` out 1: register file write enable.
- `RegDst` out 1: 0 = rt, 1 = rd.
- `ExtOp` out 1: 0 = zero-extend, 1 = sign-extend imm16.
- `ALUSrc` out 1: 0 = busB, 1 = extended immediate.
- `Branch` out 1: NPC branch select.
- `Jump` out 1: NPC jump select.
- `MemWr` out 1: data memory write.
- `MemtoReg` out 1: 0 = ALU result, 1 = memory data.
- `ALUctr` out 3: 000 add, 001 sub, 010 or, 011 slt, 100 lui (B<<16).
- `state` out 3: current state encoding.
- `illegal` out 1: undefined instruction detected.
- `instr_cnt` out 32: retired-instruction count.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 go to FETCH on the next edge.
- Supported opcodes: R-type 000000 with `func` 100000 add, 100001 addu, 100011 subu, 101010 slt; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010. Anything else is illegal.
- FETCH: IRWr = 1, PCWr = 1 (PC ← PC+4). Next state DECODE.
- DECODE (register read):
  - j: PCWr = 1, Jump = 1, go to FETCH, retire.
  - Illegal: `illegal` = 1 for this cycle, no writes, go to FETCH, not counted.
  - Otherwise: go to EXEC.
- EXEC:
  - ALUctr: R-type per func (add/addu → 000, subu → 001, slt → 011); ori → 010, ALUSrc = 1, ExtOp = 0; lui → 100, ALUSrc = 1; lw/sw → 000, ALUSrc = 1, ExtOp = 1; beq → 001, ALUSrc = 0.
  - beq: Branch = 1, PCWr = `zero`, go to FETCH, retire.
  - lw/sw: go to MEM.
  - Others: go to WB.
- MEM: ALU selects held as in EXEC.
  - sw: MemWr = 1 every cycle in MEM. On `mem_rdy` = 1, go to FETCH and retire.
  - lw: on `mem_rdy` = 1, go to WB.
  - Stay in MEM while `mem_rdy` = 0.
- WB: ALU selects held as in EXEC.
  - RegWr = 1, except `add` with `overflow` = 1 (RegWr = 0, instruction still retires).
  - RegDst = 1 for R-type, 0 otherwise. MemtoReg = 1 for lw only.
  - Go to FETCH, retire.
- All outputs not listed for a state are 0.
- `instr_cnt` increments by 1 on each retire and wraps 0xFFFFFFFF → 0.

## Timing
- Outputs are combinational from the registered `state` plus `op`/`func`/`zero`/`overflow`/`mem_rdy`. Only `state` and `instr_cnt` are registered.
- CPI: j = 2, beq = 3, R/ori/lui = 4, sw = 4 + wait cycles, lw = 5 + wait cycles.
- `rst` = 1 at an edge: `state` ← FETCH, `instr_cnt` ← 0. This holds even mid-MEM, with any pending access abandoned.
- While `rst` = 1, all strobes (PCWr, IRWr, RegWr, MemWr) and `illegal` are forced to 0; all other outputs read 0.
- The first FETCH strobes occur in the cycle after `rst` deasserts.
- `mem_rdy` is sampled only in MEM and ignored in all other states.

## Test plan
- Reset: assert `rst` 2 cycles in MEM with `mem_rdy` = 0 -> `state` = 0, `instr_cnt` = 0, all strobes 0; after release, FETCH gives IRWr = PCWr = 1.
- addu sequence (op 000000, func 100001) -> states 0,1,2,4,0; WB cycle RegWr = 1, RegDst = 1, ALUctr = 000; `instr_cnt` = 1.
- lw with `mem_rdy` low 3 cycles -> MEM held 4 cycles, MemWr = 0 throughout; WB MemtoReg = 1, RegWr = 1; total 8 cycles.
- sw then beq with `zero` = 1 then beq with `zero` = 0 -> MemWr = 1 in MEM; PCWr = 1 then 0 in the respective EXEC cycles with Branch = 1; count += 3.
- add with `overflow` = 1 -> WB RegWr = 0, `instr_cnt` still increments; op 111111 -> `illegal` pulse in DECODE, count unchanged.
- j -> DECODE PCWr = 1, Jump = 1, back to FETCH; preload `instr_cnt` to 0xFFFFFFFF via 2^32−1 retires or force -> wraps to 0.
